// File: rtl/ring_token_arbiter.sv
// Ring-token round-robin arbiter with a one-cycle dead gap between tenures.
// Define RING_TOKEN_ARBITER_TIMEOUT_EN to bound each tenure to TIMEOUT_CYCLES edges.
module ring_token_arbiter #(
  parameter int NUM_REQ        = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               Clk_In,
  input  logic               Reset_In,
  input  logic               Enable_In,
  input  logic [NUM_REQ-1:0] Req_In,
  input  logic [NUM_REQ-1:0] Done_In,
  output logic [NUM_REQ-1:0] Grant_Out,
  output logic               Busy_Out,
  output logic [NUM_REQ-1:0] Token_Out,
  output logic               Timeout_Flag_Out
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_REL
  } state_e;

  state_e             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] tok_q;
  logic               busy_q;
  logic [IW-1:0]      gidx_q;

  logic [IW-1:0]      tok_idx;
  logic [IW-1:0]      sel_d;
  logic [IW:0]        j;
  logic [IW-1:0]      nxt_idx;
  logic [NUM_REQ-1:0] tok_d;
  logic               rel_n;
  logic               rel_any;

  // Scan downward so the lowest offset from the token wins.
  always_comb begin
    tok_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (tok_q[i]) tok_idx = IW'(i);
    sel_d = '0;
    j     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = {1'b0, tok_idx} + (IW+1)'(i);
      if (j >= (IW+1)'(NUM_REQ)) j = j - (IW+1)'(NUM_REQ);
      if (Req_In[j[IW-1:0]]) sel_d = j[IW-1:0];
    end
  end

  assign nxt_idx = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
  assign tok_d   = ONE << nxt_idx;
  assign rel_n   = Done_In[gidx_q] | ~Req_In[gidx_q];

`ifdef RING_TOKEN_ARBITER_TIMEOUT_EN
  logic [15:0] cnt_q;
  logic        flag_q;
  logic        to_hit;

  assign to_hit  = (cnt_q == 16'(TIMEOUT_CYCLES - 1));
  assign rel_any = rel_n | to_hit;
`else
  assign rel_any = rel_n;
`endif

  always_ff @(negedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      tok_q   <= ONE;
      busy_q  <= 1'b0;
      gidx_q  <= '0;
`ifdef RING_TOKEN_ARBITER_TIMEOUT_EN
      cnt_q   <= '0;
      flag_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (|Req_In) begin
            state_q <= S_GRANT;
            grant_q <= ONE << sel_d;
            gidx_q  <= sel_d;
            busy_q  <= 1'b1;
`ifdef RING_TOKEN_ARBITER_TIMEOUT_EN
            cnt_q   <= '0;
            flag_q  <= 1'b0;
`endif
          end
        end
        S_GRANT: begin
          if (rel_any) begin
            state_q <= S_REL;
            grant_q <= '0;
            tok_q   <= tok_d;
`ifdef RING_TOKEN_ARBITER_TIMEOUT_EN
            // A coincident Done wins: that tenure ended normally.
            flag_q  <= to_hit & ~rel_n;
`endif
          end
`ifdef RING_TOKEN_ARBITER_TIMEOUT_EN
          else begin
            cnt_q <= cnt_q + 16'd1;
          end
`endif
        end
        S_REL: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Grant_Out = Enable_In ? grant_q : {NUM_REQ{1'bz}};
  assign Token_Out = Enable_In ? tok_q : {NUM_REQ{1'bz}};
  assign Busy_Out  = Enable_In ? busy_q : 1'bz;
`ifdef RING_TOKEN_ARBITER_TIMEOUT_EN
  assign Timeout_Flag_Out = Enable_In ? flag_q : 1'bz;
`else
  assign Timeout_Flag_Out = Enable_In ? 1'b0 : 1'bz;
`endif

endmodule

// File: tb/tb_ring_token_arbiter.sv
// Scoreboard bench for ring_token_arbiter: directed cases plus random traffic
// checked against a tenure-level reference model.
module tb_ring_token_arbiter;

  localparam int N  = 8;
  localparam int TO = 4;

  logic         clk = 1'b1;
  logic         rst = 1'b1;
  logic         en  = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] done = '0;
  wire  [N-1:0] grant;
  wire  [N-1:0] token;
  wire          busy;
  wire          tflag;

  ring_token_arbiter #(
    .NUM_REQ(N),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .Clk_In(clk),
    .Reset_In(rst),
    .Enable_In(en),
    .Req_In(req),
    .Done_In(done),
    .Grant_Out(grant),
    .Busy_Out(busy),
    .Token_Out(token),
    .Timeout_Flag_Out(tflag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] g;
    logic [N-1:0] t;
    logic         b;
    logic         f;
    logic         e;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Model: phase 0 idle, 1 granted, 2 dead gap.
  int   ph   = 0;
  int   mg   = 0;
  int   mtok = 0;
  int   ten  = 0;
  bit   mflg = 1'b0;

  task automatic check(string nm, exp_t e);
    logic [N-1:0] eg, et;
    logic         eb, ef;
    eg = e.e ? e.g : {N{1'bz}};
    et = e.e ? e.t : {N{1'bz}};
    eb = e.e ? e.b : 1'bz;
    ef = e.e ? e.f : 1'bz;
    n_vec++;
    if (grant !== eg || token !== et || busy !== eb || tflag !== ef) begin
      n_bad++;
      $display("FAIL %s t=%0t grant=%h want %h token=%h want %h busy=%b want %b flag=%b want %b",
               nm, $time, grant, eg, token, et, busy, eb, tflag, ef);
    end
  endtask

  function automatic int pick(logic [N-1:0] r);
    for (int k = 0; k < N; k++)
      if (r[(mtok + k) % N]) return (mtok + k) % N;
    return 0;
  endfunction

  task automatic model_step(logic [N-1:0] r, logic [N-1:0] d);
    bit normal, tmo;
    case (ph)
      0: if (r != '0) begin
        mg   = pick(r);
        ph   = 1;
        mflg = 1'b0;
        ten  = 0;
      end
      1: begin
        ten++;
        normal = d[mg] || !r[mg];
        tmo    = 1'b0;
`ifdef RING_TOKEN_ARBITER_TIMEOUT_EN
        tmo    = (ten >= TO);
`endif
        if (normal || tmo) begin
          mtok = (mg + 1) % N;
          ph   = 2;
          mflg = tmo && !normal;
        end
      end
      default: ph = 0;
    endcase
  endtask

  function automatic exp_t mexp(logic e);
    exp_t x;
    x.g = '0;
    if (ph == 1) x.g[mg] = 1'b1;
    x.t = '0;
    x.t[mtok] = 1'b1;
    x.b = (ph != 0);
    x.f = mflg;
    x.e = e;
    return x;
  endfunction

  task automatic step(logic [N-1:0] r, logic [N-1:0] d, logic e);
    @(posedge clk);
    req  = r;
    done = d;
    en   = e;
    model_step(r, d);
    q.push_back(mexp(e));
  endtask

  task automatic ds(string nm, logic [N-1:0] r, logic [N-1:0] d,
                    logic e, logic [N-1:0] eg, logic [N-1:0] et,
                    logic eb, logic ef);
    exp_t x;
    step(r, d, e);
    @(negedge clk);
    #2;
    x = '{g: eg, t: et, b: eb, f: ef, e: e};
    check(nm, x);
  endtask

  // Reset pulse lands between falling edges; outputs must clear at once.
  task automatic do_reset(string nm);
    exp_t x;
    @(posedge clk);
    en = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    x = '{g: '0, t: 8'h01, b: 1'b0, f: 1'b0, e: 1'b1};
    check(nm, x);
    req  = '0;
    done = '0;
    ph   = 0;
    mg   = 0;
    mtok = 0;
    ten  = 0;
    mflg = 1'b0;
    #1;
    rst = 1'b0;
    model_step('0, '0);
    q.push_back(mexp(1'b1));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (q.size() > 0) check("sb", q.pop_front());
    end
  end

  initial begin
    logic [N-1:0] r, d;
    logic         e;

    do_reset("reset");
    ds("g04",   8'h24, 8'h00, 1, 8'h04, 8'h01, 1, 0);
    ds("rel08", 8'h24, 8'h04, 1, 8'h00, 8'h08, 1, 0);
    ds("idle",  8'h24, 8'h00, 1, 8'h00, 8'h08, 0, 0);
    ds("g20",   8'h24, 8'h00, 1, 8'h20, 8'h08, 1, 0);

    do_reset("reset2");
    ds("g40",   8'h40, 8'h00, 1, 8'h40, 8'h01, 1, 0);
    ds("rel80", 8'h40, 8'h40, 1, 8'h00, 8'h80, 1, 0);
    ds("idle2", 8'h81, 8'h00, 1, 8'h00, 8'h80, 0, 0);
    ds("g80",   8'h81, 8'h00, 1, 8'h80, 8'h80, 1, 0);
    ds("rel01", 8'h81, 8'h80, 1, 8'h00, 8'h01, 1, 0);
    ds("idle3", 8'h81, 8'h00, 1, 8'h00, 8'h01, 0, 0);
    ds("g01",   8'h81, 8'h00, 1, 8'h01, 8'h01, 1, 0);

    do_reset("reset3");
    ds("g10",    8'h10, 8'h00, 1, 8'h10, 8'h01, 1, 0);
    ds("hold10", 8'h18, 8'h08, 1, 8'h10, 8'h01, 1, 0);
    do_reset("rst_mid");

    ds("g02", 8'h02, 8'h00, 1, 8'h02, 8'h01, 1, 0);
    step(8'h02, 8'h00, 0);
    step(8'h02, 8'h02, 0);
    ds("en_back", 8'h00, 8'h00, 1, 8'h00, 8'h04, 0, 0);

    do_reset("reset4");
`ifdef RING_TOKEN_ARBITER_TIMEOUT_EN
    ds("to_g", 8'h02, 8'h00, 1, 8'h02, 8'h01, 1, 0);
    for (int i = 0; i < 3; i++)
      ds("to_hold", 8'h02, 8'h00, 1, 8'h02, 8'h01, 1, 0);
    ds("to_rel",  8'h02, 8'h00, 1, 8'h00, 8'h04, 1, 1);
    ds("to_idle", 8'h02, 8'h00, 1, 8'h00, 8'h04, 0, 1);
    ds("to_g2",   8'h02, 8'h00, 1, 8'h02, 8'h04, 1, 0);
    for (int i = 0; i < 3; i++)
      ds("to_hold2", 8'h02, 8'h00, 1, 8'h02, 8'h04, 1, 0);
    ds("to_done", 8'h02, 8'h02, 1, 8'h00, 8'h04, 1, 0);
`else
    ds("ut_g", 8'h02, 8'h00, 1, 8'h02, 8'h01, 1, 0);
    for (int i = 0; i < 8; i++)
      ds("ut_hold", 8'h02, 8'h00, 1, 8'h02, 8'h01, 1, 0);
    ds("ut_rel", 8'h02, 8'h02, 1, 8'h00, 8'h04, 1, 0);
`endif

    r = '0;
    for (int it = 0; it < 3000; it++) begin
      if (it % 700 == 699) begin
        do_reset("rst_rand");
        r = '0;
      end
      d = '0;
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
        if ($urandom_range(0, 4) == 0) d[b] = 1'b1;
      end
      e = ($urandom_range(0, 9) != 0);
      step(r, d, e);
    end

    @(negedge clk);
    #2;
    @(negedge clk);
    #2;
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
